uart_xcvr: RTL
==============

Name: uart_xcvr

Overview:
- Parametrised full-duplex UART transceiver. Successor to the fixed 8N1 UART used by the Riscv151 memory-mapped I/O.
- Configurable data width, parity, stop bits and RX oversampling.
- Ready/valid byte interfaces toward the CPU MMIO decoder; FPGA_SERIAL_RX/TX toward the pins.
- Reports framing, parity and overrun errors per received frame.

Parameters:
- CLOCK_FREQ, 50_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits per second.
- DATA_BITS, 8: payload bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: RX samples per bit; must be an even number, 4 or more.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter idle; the byte is accepted when tx_valid and tx_ready are both high.
- rx_data  out  DATA_BITS  received payload.
- rx_valid  out  1  rx_data holds an unread frame.
- rx_ready  in  1  consumer takes rx_data when rx_valid and rx_ready are both high.
- rx_frame_err  out  1  sticky; set when a stop bit samples 0.
- rx_parity_err  out  1  sticky; set on parity mismatch.
- rx_overrun  out  1  sticky; set when a frame completes while rx_valid is already high.
- err_clear  in  1  one-cycle pulse that clears all three sticky error flags.
- serial_in  in  1  asynchronous line input.
- serial_out  out  1  line output; idles high.

Behaviour:
- Baud timing:
  - Bit period BIT_CYC = CLOCK_FREQ/BAUD_RATE, integer-truncated.
  - RX sample tick SAMP_CYC = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated.
  - Counter widths are $clog2 of the terminal value plus 1.
- Reset values: serial_out=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0. Both FSMs go to IDLE.
  - Reset asserted mid-frame aborts the frame immediately.
  - serial_out returns to 1 on the cycle after rst is sampled.
- TX FSM states: IDLE -> START -> DATA -> PAR -> STOP -> IDLE.
  - On the handshake, tx_data is latched and tx_ready drops on the next cycle.
  - serial_out goes 0 on that same next cycle.
  - Each state holds serial_out for exactly BIT_CYC cycles.
  - DATA shifts LSB first for DATA_BITS bits.
  - PAR is skipped when PARITY=0. Parity bit = XOR of the data bits, inverted when PARITY=1 (odd).
  - STOP holds 1 for STOP_BITS*BIT_CYC cycles. tx_ready rises on the first cycle back in IDLE.
  - Back-to-back frames have no extra idle gap.
- RX front end: serial_in passes through a 2-flop synchronizer, reset value 1.
- RX FSM states: IDLE -> START -> DATA -> PAR -> STOP -> IDLE.
  - IDLE: a synchronized 1->0 edge enters START.
  - START: waits OVERSAMPLE/2 ticks, then samples the line.
    - If the sample is 1, the start was false: return to IDLE with no flags and no output.
  - Each subsequent bit is sampled once, OVERSAMPLE ticks after the previous sample (mid-bit).
  - Only the first stop bit is checked.
- Frame completion happens at the stop-bit sample:
  - If rx_valid=0: rx_data is loaded and rx_valid rises on the next cycle.
  - If rx_valid=1: the new frame is dropped, rx_data is unchanged, and rx_overrun is set.
  - A stop bit sampled as 0 sets rx_frame_err, but the data is still delivered.
  - A parity mismatch sets rx_parity_err, but the data is still delivered.
  - The RX FSM returns to IDLE right after the stop sample, so back-to-back frames are accepted.
- rx_valid clears on the handshake cycle. Handshake and frame completion in the same cycle: the new data loads and rx_valid stays 1; no overrun is flagged.
- err_clear coinciding with a new error event: the set wins.

Optional Feature:
- Macro: UART_XCVR_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the RX synchronizer input is serial_out instead of serial_in, and the serial_out pin is forced to 1.
  - Switching loopback mid-frame is allowed; the frame in flight may be corrupted or flagged.
- Not defined: the port is absent and RX always uses serial_in.

Decomposition:
- Package uart_pkg holds:
  - the parity encoding constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the FSM state enum shared by TX and RX;
  - the BIT_CYC and SAMP_CYC calculation functions.
- One sub-module, uart_baud_counter: a parametrised terminal-count tick generator. It is instantiated once for the TX bit period and once for the RX sample tick.
- TX and RX FSMs stay in uart_xcvr.

Test Plan:
All scenarios use CLOCK_FREQ=50e6, BAUD_RATE=115200, so BIT_CYC=434.
1. 8N1: send 8'h78 -> serial_out low for 434 cycles, then bits 0,0,0,1,1,1,1,0, then high. tx_ready returns high 4340 cycles after the handshake.
2. Drive 8'h0d on serial_in at 8680 ns per bit -> rx_data=8'h0d, rx_valid=1, all error flags 0.
3. DATA_BITS=7, PARITY=2 (even): receive 7'h31 with a bad parity bit -> rx_data=7'h31, rx_parity_err=1. Then err_clear -> flag returns to 0.
4. Receive 8'h79 with a 0 stop bit -> rx_frame_err=1. Then a low glitch of 2 sample ticks (under half a bit) -> no rx_valid.
5. Send two frames 8'h7a and 8'h0d with rx_ready held 0 -> rx_data=8'h7a, rx_overrun=1.
6. With UART_XCVR_LOOPBACK_EN and loopback=1, send 8'h3e -> rx_data=8'h3e and the serial_out pin stays 1 throughout. Then assert rst mid-frame -> serial_out=1 and tx_ready=1 on the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transceiver: parity
// encodings, the FSM state type used by both TX and RX, and the baud
// timing helpers.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_state_t;

    // Clock cycles per serial bit, truncated.
    function automatic int calc_bit_cyc(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Clock cycles per RX oversampling tick, truncated.
    function automatic int calc_samp_cyc(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running terminal-count tick generator. Held at zero while i_clr is
// high so the first tick after release lands exactly TERM cycles later.
module uart_baud_counter #(
    parameter int TERM = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(TERM) + 1;
    localparam logic [CW-1:0] LAST = CW'(TERM - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..TERM-1 and wrap; clear restarts the period.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver with configurable width, parity, stop bits
// and RX oversampling. Ready/valid byte interfaces on the core side.
// Optional build macro UART_XCVR_LOOPBACK_EN adds a 'loopback' input that
// routes the transmitter into the receiver and parks the pin high.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 err_clear,
    input  logic                 serial_in,
    output logic                 serial_out
`ifdef UART_XCVR_LOOPBACK_EN
    ,
    input  logic                 loopback
`endif
);

    localparam int BIT_CYC  = calc_bit_cyc(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMP_CYC = calc_samp_cyc(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);

    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    localparam int TW = $clog2(OVERSAMPLE) + 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

    localparam bit   HAS_PAR = (PARITY != PAR_NONE);
    localparam logic ODD_INV = (PARITY == PAR_ODD);

    // ---------------- transmitter ----------------
    uart_state_t          r_tx_state, w_tx_next;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic [BW-1:0]        r_tx_cnt;
    logic                 w_tx_tick;
    logic                 w_tx_clr;
    logic                 w_tx_line;

    assign w_tx_clr = (r_tx_state == ST_IDLE);

    uart_baud_counter #(.TERM(BIT_CYC)) u_tx_baud (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_tx_clr),
        .o_tick (w_tx_tick)
    );

    // TX state register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) r_tx_state <= ST_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    // TX next-state: every bit lasts one baud period.
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            ST_IDLE:  if (tx_valid) w_tx_next = ST_START;
            ST_START: if (w_tx_tick) w_tx_next = ST_DATA;
            ST_DATA:  if (w_tx_tick && r_tx_cnt == LAST_DATA)
                          w_tx_next = HAS_PAR ? ST_PAR : ST_STOP;
            ST_PAR:   if (w_tx_tick) w_tx_next = ST_STOP;
            ST_STOP:  if (w_tx_tick && r_tx_cnt == LAST_STOP) w_tx_next = ST_IDLE;
            default:  w_tx_next = ST_IDLE;
        endcase
    end

    // TX outputs: line level per state, ready only while idle.
    always_comb begin
        tx_ready  = (r_tx_state == ST_IDLE);
        w_tx_line = 1'b1;
        case (r_tx_state)
            ST_START: w_tx_line = 1'b0;
            ST_DATA:  w_tx_line = r_tx_shift[0];
            ST_PAR:   w_tx_line = r_tx_par;
            default:  w_tx_line = 1'b1;
        endcase
`ifdef UART_XCVR_LOOPBACK_EN
        serial_out = loopback ? 1'b1 : w_tx_line;
`else
        serial_out = w_tx_line;
`endif
    end

    // Latch the payload and its parity on handshake, shift out LSB first.
    always_ff @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            r_tx_shift <= tx_data;
            r_tx_par   <= (^tx_data) ^ ODD_INV;
        end else if (r_tx_state == ST_DATA && w_tx_tick) begin
            r_tx_shift <= r_tx_shift >> 1;
        end
    end

    // Bits sent within the current state (data bits or stop bits).
    always_ff @(posedge clk) begin
        if (rst || r_tx_state != w_tx_next) r_tx_cnt <= '0;
        else if (w_tx_tick)                 r_tx_cnt <= r_tx_cnt + BW'(1);
    end

    // ---------------- receiver ----------------
    uart_state_t          r_rx_state, w_rx_next;
    logic [1:0]           r_rx_sync;
    logic                 r_rx_prev;
    logic [TW-1:0]        r_rx_ticks;
    logic [BW-1:0]        r_rx_cnt;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par;
    logic                 w_rx_pin;
    logic                 w_rx_line;
    logic                 w_rx_fall;
    logic                 w_samp_tick;
    logic                 w_rx_clr;
    logic                 w_rx_sample;
    logic                 w_rx_shift_en;
    logic                 w_rx_par_en;
    logic                 w_rx_done;
    logic                 w_rx_par_bad;

`ifdef UART_XCVR_LOOPBACK_EN
    assign w_rx_pin = loopback ? w_tx_line : serial_in;
`else
    assign w_rx_pin = serial_in;
`endif

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sync <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_sync <= {r_rx_sync[0], w_rx_pin};
            r_rx_prev <= r_rx_sync[1];
        end
    end

    assign w_rx_line = r_rx_sync[1];
    assign w_rx_fall = r_rx_prev & ~w_rx_line;
    assign w_rx_clr  = (r_rx_state == ST_IDLE);

    uart_baud_counter #(.TERM(SAMP_CYC)) u_rx_baud (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_rx_clr),
        .o_tick (w_samp_tick)
    );

    // Half a bit after the start edge, then a full bit per sample.
    assign w_rx_sample = w_samp_tick &&
                         ((r_rx_state == ST_START) ? (r_rx_ticks == HALF_LAST)
                                                   : (r_rx_ticks == FULL_LAST));

    // Oversampling ticks since the last sample point.
    always_ff @(posedge clk) begin
        if (rst || w_rx_clr || w_rx_sample) r_rx_ticks <= '0;
        else if (w_samp_tick)               r_rx_ticks <= r_rx_ticks + TW'(1);
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst) r_rx_state <= ST_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    // RX next-state: one sample per bit, false starts fall back to idle.
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            ST_IDLE:  if (w_rx_fall) w_rx_next = ST_START;
            ST_START: if (w_rx_sample) w_rx_next = w_rx_line ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_rx_sample && r_rx_cnt == LAST_DATA)
                          w_rx_next = HAS_PAR ? ST_PAR : ST_STOP;
            ST_PAR:   if (w_rx_sample) w_rx_next = ST_STOP;
            ST_STOP:  if (w_rx_sample) w_rx_next = ST_IDLE;
            default:  w_rx_next = ST_IDLE;
        endcase
    end

    // RX strobes decoded from the current state and sample point.
    always_comb begin
        w_rx_shift_en = (r_rx_state == ST_DATA) && w_rx_sample;
        w_rx_par_en   = (r_rx_state == ST_PAR)  && w_rx_sample;
        w_rx_done     = (r_rx_state == ST_STOP) && w_rx_sample;
    end

    // Data bits received in the current frame.
    always_ff @(posedge clk) begin
        if (rst || r_rx_state != w_rx_next) r_rx_cnt <= '0;
        else if (w_rx_shift_en)             r_rx_cnt <= r_rx_cnt + BW'(1);
    end

    // Assemble the payload LSB first and keep the received parity bit.
    always_ff @(posedge clk) begin
        if (w_rx_shift_en) r_rx_shift <= {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
        if (w_rx_par_en)   r_rx_par   <= w_rx_line;
    end

    assign w_rx_par_bad = HAS_PAR && (r_rx_par != ((^r_rx_shift) ^ ODD_INV));

    // Deliver a completed frame unless an unread one is still held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (w_rx_done && (!rx_valid || rx_ready)) begin
            rx_valid <= 1'b1;
            rx_data  <= r_rx_shift;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (w_rx_done && !w_rx_line)                   rx_frame_err  <= 1'b1;
            else if (err_clear)                            rx_frame_err  <= 1'b0;
            if (w_rx_done && w_rx_par_bad)                 rx_parity_err <= 1'b1;
            else if (err_clear)                            rx_parity_err <= 1'b0;
            if (w_rx_done && rx_valid && !rx_ready)        rx_overrun    <= 1'b1;
            else if (err_clear)                            rx_overrun    <= 1'b0;
        end
    end

endmodule
